// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Package : bp_pkg
// Shared types and counter-table geometry for the tournament branch predictor.
// Rev     : 1.0
// ============================================================================
package bp_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ctr_state_e;

    localparam int LOCAL_CTR_W  = 3;
    localparam int GLOBAL_CTR_W = 2;
    localparam int CHOICE_CTR_W = 2;

    localparam int LOCAL_IDX_W  = 10;
    localparam int GLOBAL_IDX_W = 12;
    localparam int CHOICE_IDX_W = 12;

endpackage
`default_nettype wire

// File: rtl/sat_counter_table_next.sv
`default_nettype none
// ============================================================================
// Module : sat_ctr_next
// Combinational saturating step of one counter: up on taken, down otherwise.
// Rev    : 1.0
// ============================================================================
module sat_ctr_next
    import bp_pkg::*;
#(
    parameter int CTR_WIDTH = GLOBAL_CTR_W
) (
    input  logic [CTR_WIDTH-1:0] ctr_i,
    input  logic                 taken_i,
    output logic [CTR_WIDTH-1:0] ctr_o
);

    localparam logic [CTR_WIDTH-1:0] C_MAX = '1;

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != C_MAX) begin
                ctr_o = ctr_i + CTR_WIDTH'(1);
            end
        end else if (ctr_i != '0) begin
            ctr_o = ctr_i - CTR_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sat_counter_table.sv
`default_nettype none
// ============================================================================
// Module : sat_counter_table
// Table of saturating counters: registered predict with write-first bypass,
// saturating update and a one-entry-per-cycle clear sweep.
// Rev    : 1.0
// ============================================================================
module sat_counter_table
    import bp_pkg::*;
#(
    parameter int CTR_WIDTH   = GLOBAL_CTR_W,
    parameter int INDEX_WIDTH = LOCAL_IDX_W,
    parameter int INIT_VALUE  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pred_valid_i,
    input  logic [INDEX_WIDTH-1:0] pred_index_i,
    output logic                   pred_valid_o,
    output logic                   pred_taken_o,
    output logic [CTR_WIDTH-1:0]   pred_ctr_o,
    input  logic                   upd_valid_i,
    input  logic [INDEX_WIDTH-1:0] upd_index_i,
    input  logic                   upd_taken_i,
    input  logic                   clear_i,
    output logic                   busy_o
);

    localparam int                     DEPTH    = 2**INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0]   C_INIT   = CTR_WIDTH'(INIT_VALUE);
    localparam logic [INDEX_WIDTH-1:0] C_LAST   = '1;
    localparam logic [0:0]             ST_IDLE  = IDLE;
    localparam logic [0:0]             ST_CLEAR = CLEAR;

    logic [CTR_WIDTH-1:0]   table_q [DEPTH];
    logic [0:0]             state_q, state_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic                   pred_valid_q;
    logic [CTR_WIDTH-1:0]   pred_ctr_q, pred_ctr_d;

    logic                   upd_en;
    logic                   pred_en;
    logic [CTR_WIDTH-1:0]   upd_cur;
    logic [CTR_WIDTH-1:0]   upd_next;

    // A clear request in the same IDLE cycle wins over an update.
    assign upd_en  = (state_q == ST_IDLE) && upd_valid_i && !clear_i;
    assign pred_en = (state_q == ST_IDLE) && pred_valid_i;
    assign upd_cur = table_q[upd_index_i];

    sat_ctr_next #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_next (
        .ctr_i   (upd_cur),
        .taken_i (upd_taken_i),
        .ctr_o   (upd_next)
    );

    assign pred_ctr_d = (upd_en && (upd_index_i == pred_index_i)) ? upd_next
                                                                  : table_q[pred_index_i];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (clear_i) begin
                    ptr_d = '0;
                end else if (ptr_q == C_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + INDEX_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= C_INIT;
            end
        end else if (state_q == ST_CLEAR) begin
            table_q[ptr_q] <= C_INIT;
        end else if (upd_en) begin
            table_q[upd_index_i] <= upd_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
        end else begin
            pred_valid_q <= pred_en;
            if (pred_en) begin
                pred_ctr_q <= pred_ctr_d;
            end
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_ctr_o   = pred_ctr_q;
    assign pred_taken_o = pred_ctr_q[CTR_WIDTH-1];
    assign busy_o       = (state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_sat_counter_table.sv
`default_nettype none
// ============================================================================
// Module : tb_sat_counter_table
// Self-checking bench for sat_counter_table against an array reference model.
// Rev    : 1.0
// ============================================================================
module tb_sat_counter_table;

    localparam int W0 = 2, IW0 = 10, INIT0 = 1, D0 = 1024;
    localparam int W1 = 3, IW1 = 4,  INIT1 = 3, D1 = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic           pv, uv, ut, clr;
    logic [IW0-1:0] pi, ui;
    logic           pvo, pto, busy;
    logic [W0-1:0]  pco;

    logic           b_pv, b_uv, b_ut, b_clr;
    logic [IW1-1:0] b_pi, b_ui;
    logic           b_pvo, b_pto, b_busy;
    logic [W1-1:0]  b_pco;

    int total = 0;
    int bad   = 0;
    int model0 [D0];
    int model1 [D1];
    int exp_c;
    bit exp_v;

    sat_counter_table #(.CTR_WIDTH(W0), .INDEX_WIDTH(IW0), .INIT_VALUE(INIT0)) dut (
        .clock(clock), .reset(reset),
        .pred_valid_i(pv), .pred_index_i(pi),
        .pred_valid_o(pvo), .pred_taken_o(pto), .pred_ctr_o(pco),
        .upd_valid_i(uv), .upd_index_i(ui), .upd_taken_i(ut),
        .clear_i(clr), .busy_o(busy)
    );

    sat_counter_table #(.CTR_WIDTH(W1), .INDEX_WIDTH(IW1), .INIT_VALUE(INIT1)) dut_w (
        .clock(clock), .reset(reset),
        .pred_valid_i(b_pv), .pred_index_i(b_pi),
        .pred_valid_o(b_pvo), .pred_taken_o(b_pto), .pred_ctr_o(b_pco),
        .upd_valid_i(b_uv), .upd_index_i(b_ui), .upd_taken_i(b_ut),
        .clear_i(b_clr), .busy_o(b_busy)
    );

    function automatic int sat(input int v, input bit t, input int w);
        int mx;
        mx = (1 << w) - 1;
        if (t) return (v < mx) ? v + 1 : mx;
        return (v > 0) ? v - 1 : 0;
    endfunction

    task automatic model_init();
        for (int i = 0; i < D0; i++) model0[i] = INIT0;
        for (int i = 0; i < D1; i++) model1[i] = INIT1;
        exp_c = 0;
        exp_v = 1'b0;
    endtask

    // One IDLE-state cycle on the 2-bit table; reference model follows the rules.
    task automatic cyc(input bit p, input int pidx, input bit u, input int uidx,
                       input bit t, input bit c);
        @(negedge clock);
        pv = p; pi = IW0'(pidx); uv = u; ui = IW0'(uidx); ut = t; clr = c;
        @(posedge clock); #1;
        if (u && !c) model0[uidx] = sat(model0[uidx], t, W0);
        if (p) exp_c = model0[pidx];
        exp_v = p;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        pv = 0; pi = '0; uv = 0; ui = '0; ut = 0; clr = 0;
        b_pv = 0; b_pi = '0; b_uv = 0; b_ui = '0; b_ut = 0; b_clr = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_init();
    endtask

    task automatic read_all();
        for (int i = 0; i < D0; i++) begin
            cyc(1, i, 0, 0, 0, 0);
            total++;
            if (pvo !== 1'b1 || pco !== W0'(exp_c)) begin
                bad++;
                $display("FAIL readback idx=%0d valid=%0b ctr=%0d expected valid=1 ctr=%0d",
                         i, pvo, pco, exp_c);
            end
        end
    endtask

    // Starts a sweep (with a same-cycle update that must be dropped) and
    // counts busy cycles while random requests are thrown at the table.
    task automatic run_clear(input int stop_after, output int n);
        @(negedge clock);
        pv = 0; uv = 1; ui = '0; ut = 1; clr = 1;
        @(posedge clock); #1;
        n = busy ? 1 : 0;
        while (busy && n < stop_after) begin
            @(negedge clock);
            pv = 1'($urandom); pi = IW0'($urandom); uv = 1'($urandom);
            ui = IW0'($urandom); ut = 1'($urandom); clr = 0;
            @(posedge clock); #1;
            total++;
            if (pvo !== 1'b0) begin
                bad++;
                $display("FAIL clear_pred_valid valid=%0b expected 0", pvo);
            end
            if (busy) n++;
        end
        for (int i = 0; i < D0; i++) model0[i] = INIT0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (pvo !== 1'b0 || pto !== 1'b0 || pco !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state valid=%0b taken=%0b ctr=%0d busy=%0b expected all 0",
                     pvo, pto, pco, busy);
        end
        total++;
        if (b_pvo !== 1'b0 || b_pco !== '0 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state_wide valid=%0b ctr=%0d busy=%0b expected all 0",
                     b_pvo, b_pco, b_busy);
        end
    endtask

    task automatic test_predict_basic();
        cyc(1, 5, 0, 0, 0, 0);
        total++;
        if (pvo !== 1'b1 || pco !== 2'd1 || pto !== 1'b0) begin
            bad++;
            $display("FAIL predict_init valid=%0b ctr=%0d taken=%0b expected 1/1/0", pvo, pco, pto);
        end
        cyc(0, 0, 0, 0, 0, 0);
        total++;
        if (pvo !== 1'b0 || pco !== 2'd1) begin
            bad++;
            $display("FAIL predict_hold valid=%0b ctr=%0d expected 0/1", pvo, pco);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 5, 1, 0);
        cyc(1, 5, 0, 0, 0, 0);
        total++;
        if (pco !== 2'd3 || pto !== 1'b1 || pco !== W0'(exp_c)) begin
            bad++;
            $display("FAIL sat_high ctr=%0d taken=%0b expected 3/1", pco, pto);
        end
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 5, 0, 0);
        cyc(1, 5, 0, 0, 0, 0);
        total++;
        if (pco !== 2'd0 || pto !== 1'b0) begin
            bad++;
            $display("FAIL sat_low ctr=%0d taken=%0b expected 0/0", pco, pto);
        end
    endtask

    task automatic test_bypass();
        cyc(1, 7, 1, 7, 1, 0);
        total++;
        if (pvo !== 1'b1 || pco !== 2'd2 || pto !== 1'b1) begin
            bad++;
            $display("FAIL bypass valid=%0b ctr=%0d taken=%0b expected 1/2/1", pvo, pco, pto);
        end
    endtask

    task automatic test_back_to_back();
        cyc(0, 0, 1, 9, 1, 0);
        cyc(1, 9, 1, 9, 1, 0);
        total++;
        if (pco !== 2'd3 || pco !== W0'(exp_c)) begin
            bad++;
            $display("FAIL back_to_back ctr=%0d expected 3", pco);
        end
        cyc(1, 10, 1, 11, 0, 0);
        total++;
        if (pco !== 2'd1) begin
            bad++;
            $display("FAIL independent_idx ctr=%0d expected 1", pco);
        end
        cyc(1, 11, 0, 0, 0, 0);
        total++;
        if (pco !== 2'd0) begin
            bad++;
            $display("FAIL independent_upd ctr=%0d expected 0", pco);
        end
    endtask

    task automatic test_wide_counter();
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            b_pv = 0; b_uv = 1; b_ui = 4'd2; b_ut = 1;
            @(posedge clock); #1;
            model1[2] = sat(model1[2], 1, W1);
        end
        @(negedge clock);
        b_uv = 0; b_pv = 1; b_pi = 4'd2;
        @(posedge clock); #1;
        total++;
        if (b_pvo !== 1'b1 || b_pco !== W1'(model1[2]) || b_pco !== 3'd7 || b_pto !== 1'b1) begin
            bad++;
            $display("FAIL wide_sat valid=%0b ctr=%0d taken=%0b expected 1/7/1", b_pvo, b_pco, b_pto);
        end
        @(negedge clock);
        b_pv = 0; b_uv = 1; b_ut = 0;
        @(posedge clock); #1;
        model1[2] = sat(model1[2], 0, W1);
        @(negedge clock);
        b_uv = 0; b_pv = 1;
        @(posedge clock); #1;
        total++;
        if (b_pco !== W1'(model1[2]) || b_pco !== 3'd6 || b_pto !== 1'b1) begin
            bad++;
            $display("FAIL wide_dec ctr=%0d taken=%0b expected 6/1", b_pco, b_pto);
        end
        @(negedge clock);
        b_pv = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom), $urandom_range(0, 15), 1'($urandom), $urandom_range(0, 15),
                1'($urandom), 0);
            total++;
            if (pvo !== exp_v || pco !== W0'(exp_c) || pto !== exp_c[W0-1]) begin
                bad++;
                $display("FAIL random cycle=%0d valid=%0b ctr=%0d taken=%0b expected %0b/%0d/%0b",
                         k, pvo, pco, pto, exp_v, exp_c, exp_c[W0-1]);
            end
        end
    endtask

    task automatic test_clear();
        int n;
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1023, 0, 0);
        cyc(0, 0, 1, 512, 1, 0);
        run_clear(3 * D0, n);
        total++;
        if (n !== D0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_busy_len cycles=%0d busy=%0b expected %0d/0", n, busy, D0);
        end
        read_all();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        cyc(0, 0, 1, 3, 1, 0);
        cyc(0, 0, 1, 1000, 0, 0);
        run_clear(500, n);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || pvo !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_sweep busy=%0b valid=%0b expected 0/0", busy, pvo);
        end
        @(negedge clock);
        pv = 0; uv = 0; clr = 0;
        @(negedge clock);
        reset = 1'b0;
        model_init();
        read_all();
        cyc(0, 0, 1, 0, 1, 0);
        run_clear(3 * D0, n);
        total++;
        if (n !== D0) begin
            bad++;
            $display("FAIL sweep_after_reset cycles=%0d expected %0d", n, D0);
        end
        cyc(1, 0, 0, 0, 0, 0);
        total++;
        if (pco !== W0'(INIT0)) begin
            bad++;
            $display("FAIL sweep_idx0 ctr=%0d expected %0d", pco, INIT0);
        end
    endtask

    initial begin
        reset = 1'b1;
        pv = 0; pi = '0; uv = 0; ui = '0; ut = 0; clr = 0;
        b_pv = 0; b_pi = '0; b_uv = 0; b_ui = '0; b_ut = 0; b_clr = 0;
        model_init();
        test_reset();
        test_predict_basic();
        test_saturation();
        test_bypass();
        test_back_to_back();
        test_wide_counter();
        test_random();
        test_clear();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sat_counter_table.md
Name: sat_counter_table

Overview:
- Parametrised table of N-bit saturating counters; generalises the single 2-bit predictor counter to DEPTH entries.
- Indexed predict port: registered, 1-cycle latency.
- Indexed update port: saturating read-modify-write.
- Synchronous table-clear sweep FSM.
- Serves as the common building block for the local (3-bit), global (2-bit) and choice (2-bit) tables of the tournament predictor.

Parameters:
- CTR_WIDTH, 2: bits per counter, >=2; prediction = counter MSB.
- INDEX_WIDTH, 10: table index width; DEPTH = 2**INDEX_WIDTH.
- INIT_VALUE, 1: counter value after reset/clear (weakly not-taken for 2-bit); must be < 2**CTR_WIDTH.

Ports:
- clock  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- pred_valid_i  input  1  prediction request.
- pred_index_i  input  INDEX_WIDTH  entry to read.
- pred_valid_o  output  1  pred_taken_o/pred_ctr_o valid this cycle.
- pred_taken_o  output  1  MSB of addressed counter.
- pred_ctr_o  output  CTR_WIDTH  full counter value (feeds choice logic/debug).
- upd_valid_i  input  1  resolved-branch update.
- upd_index_i  input  INDEX_WIDTH  entry to update.
- upd_taken_i  input  1  actual outcome: 1 = increment, 0 = decrement.
- clear_i  input  1  start table-clear sweep.
- busy_o  output  1  clear sweep in progress.

Behaviour:
- Reset is asynchronous, active-high, clock is clock. On reset:
  - every counter = INIT_VALUE;
  - pred_valid_o = 0, pred_taken_o = 0, pred_ctr_o = 0, busy_o = 0;
  - FSM = IDLE, sweep pointer = 0.
- Predict, IDLE only: sample pred_index_i on edge N when pred_valid_i=1; outputs registered and valid after edge N.
  - pred_valid_o is high exactly one cycle per accepted request.
  - Without a request, pred_valid_o=0 and data outputs hold their last values.
- Update, IDLE only, at each edge with upd_valid_i=1:
  - upd_taken_i=1: ctr <= (ctr == 2**CTR_WIDTH-1) ? ctr : ctr+1.
  - upd_taken_i=0: ctr <= (ctr == 0) ? 0 : ctr-1.
  - Saturate at both ends, no wrap.
- Same-cycle predict and update to the same index: write-first bypass. The prediction returns the post-update value. Different indices are independent.
- Back-to-back updates to the same index on consecutive cycles: each sees the previous result, with no lost updates.
- FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR when clear_i=1. busy_o=1 from the next cycle. The pointer starts at 0.
  - CLEAR: write INIT_VALUE to entry[pointer] each cycle, then pointer+1. After writing DEPTH-1, go to IDLE with pointer = 0. busy_o is high for exactly DEPTH cycles.
  - In CLEAR, pred_valid_i and upd_valid_i are ignored (dropped, not queued) and pred_valid_o=0.
  - clear_i asserted in CLEAR restarts the sweep at pointer 0.
  - clear_i and upd_valid_i in the same IDLE cycle: the update is dropped and clear wins.
- Reset mid-sweep: immediate IDLE, full table = INIT_VALUE, busy_o=0.
- Storage is flops (async reset requires it). Index arithmetic is unsigned INDEX_WIDTH; the pointer wraps naturally at DEPTH.

Decomposition:
- Package bp_pkg holds:
  - ctr_state_e enum {IDLE, CLEAR};
  - shared CTR_WIDTH defaults: LOCAL_CTR_W=3, GLOBAL_CTR_W=2, CHOICE_CTR_W=2;
  - INDEX_WIDTH defaults: LOCAL=10, GLOBAL=12, CHOICE=12.
- One sub-module, sat_ctr_next: combinational next-value function (ctr, taken -> saturated ctr). It is parametrised by CTR_WIDTH and reused by the choice-update logic.

Test Plan:
- Reset then predict index 5 (CTR_WIDTH=2, INIT_VALUE=1): next cycle pred_valid_o=1, pred_ctr_o=01, pred_taken_o=0.
- Four taken updates to index 5, then predict: ctr 01->10->11->11->11, pred_ctr_o=11, pred_taken_o=1. Five not-taken updates give 00, with no underflow wrap.
- Same cycle: predict index 7 and update index 7 taken, ctr=01: response pred_ctr_o=10 (bypass), pred_taken_o=1.
- CTR_WIDTH=3, INIT_VALUE=3: eight taken updates saturate at 111. One not-taken gives 110, pred_taken_o still 1.
- Write several entries, pulse clear_i: busy_o high exactly DEPTH cycles, pred_valid_o stays 0 during the sweep, requests are dropped. After the sweep every index reads INIT_VALUE.
- Assert reset midway through the sweep: busy_o drops asynchronously, all entries read INIT_VALUE afterwards. A subsequent clear_i sweep starts from index 0.
